// File: rtl/uart_rx_ctrl.sv
// UART receiver: 2-flop rx synchroniser, oversampled start/data/stop sequencing,
// byte delivery with a one-clock done strobe and a framing-error qualifier.
module uart_rx_ctrl #(
    parameter int DBIT    = 8,
    parameter int OS      = 16,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            busy
);

    localparam int SMAX = (OS > SB_TICK) ? OS : SB_TICK;
    localparam int SW   = (SMAX > 1) ? $clog2(SMAX) : 1;
    localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_MID  = SW'(OS/2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OS - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            frame_err_q, frame_err_d;
    logic            busy_q, busy_d;
    logic            rx_meta_q, rx_s_q;

    // State register; synchroniser idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= IDLE;
            s_q         <= '0;
            n_q         <= '0;
            b_q         <= '0;
            dout_q      <= '0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            b_q         <= b_d;
            dout_q      <= dout_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    // Next state; a tick that causes a transition does not also advance s.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        n_d         = n_q;
        b_d         = b_q;
        dout_d      = dout_q;
        frame_err_d = frame_err_q;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        s_d = '0;
                        if (!rx_s_q) begin
                            state_d = DATA;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_BIT) begin
                        s_d           = '0;
                        b_d           = b_q >> 1;
                        b_d[DBIT-1]   = rx_s_q;
                        if (n_q == N_LAST) state_d = STOP;
                        else               n_d = n_q + NW'(1);
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP) begin
                        state_d     = IDLE;
                        s_d         = '0;
                        dout_d      = b_q;
                        frame_err_d = ~rx_s_q;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobe spans the clock whose closing edge loads dout/frame_err.
    always_comb begin
        rx_done_tick = (state_q == STOP) && s_tick && (s_q == S_STOP);
        busy_d       = (state_d != IDLE);
    end

    assign dout      = dout_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule
